// File: rtl/imem_line_fetch.sv
`timescale 1ns/1ps
// imem_line_fetch: fetches one instruction line as 32-bit beats over a
// req/gnt/rvalid memory port and presents it as a single-cycle line pulse.
module imem_line_fetch #(
  parameter int unsigned LINEWIDTH = 64,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_line,
  input  logic [31:0]          line_addr_i,
  input  logic                 flush,
  output logic                 line_ready,
  output logic                 line_valid,
  output logic [LINEWIDTH-1:0] line_in,
  output logic                 line_err_o,
  output logic                 mem_req_o,
  output logic [31:0]          mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_err_i
);

  localparam int unsigned BEATS = LINEWIDTH / 32;
  localparam int unsigned BW    = $clog2(BEATS);
  localparam int unsigned OFFW  = $clog2(LINEWIDTH / 8);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [31:0]          base_q;
  logic [BW-1:0]        beat_q;
  logic                 err_q;
  logic [TW-1:0]        tcnt_q;
  logic [LINEWIDTH-1:0] buf_q;
  logic [LINEWIDTH-1:0] line_q;
  logic [LINEWIDTH-1:0] assembled;
  logic                 start;
  logic                 store_beat;
  logic                 beat_inc;
  logic                 tcnt_clr;
  logic                 tcnt_inc;
  logic                 addr_lo_unused;

  // Offset bits inside the line are deliberately ignored.
  assign addr_lo_unused = ^line_addr_i[OFFW-1:0];

  // Line buffer with the current response beat merged in (final-beat bypass).
  always_comb begin
    assembled = buf_q;
    assembled[int'(beat_q) * 32 +: 32] = mem_rdata_i;
  end

  // Next-state and handshake decode; flush always wins over completion/timeout.
  always_comb begin
    state_d    = state_q;
    line_ready = 1'b0;
    line_valid = 1'b0;
    line_err_o = 1'b0;
    mem_req_o  = 1'b0;
    start      = 1'b0;
    store_beat = 1'b0;
    beat_inc   = 1'b0;
    tcnt_clr   = 1'b0;
    tcnt_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        line_ready = 1'b1;
        if (ld_line && !flush) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          tcnt_clr = 1'b1;
          state_d  = flush ? DRAIN : RESP;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (mem_rvalid_i) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            store_beat = 1'b1;
            if (beat_q == LAST_BEAT) begin
              line_valid = 1'b1;
              line_err_o = err_q | mem_err_i;
              state_d    = IDLE;
            end else begin
              beat_inc = 1'b1;
              state_d  = REQ;
            end
          end
        end else if (flush) begin
          state_d = DRAIN;
        end else if (tcnt_q == TMO_LAST) begin
          // The granted beat is still owed, so drain it after reporting the error.
          line_valid = 1'b1;
          line_err_o = 1'b1;
          state_d    = DRAIN;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output line: live during the pulse, otherwise the last delivered line.
  always_comb begin
    line_in = line_q;
    if (line_valid) line_in = store_beat ? assembled : buf_q;
  end

  assign mem_addr_o = mem_req_o ? (base_q + {{(30 - BW){1'b0}}, beat_q, 2'b00}) : '0;

  // State, beat bookkeeping, line buffer and response timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_in;
      if (start) begin
        base_q <= {line_addr_i[31:OFFW], {OFFW{1'b0}}};
        beat_q <= '0;
        err_q  <= 1'b0;
      end else if (beat_inc) begin
        beat_q <= beat_q + BW'(1);
      end
      if (store_beat) begin
        buf_q <= assembled;
        err_q <= err_q | mem_err_i;
      end
      if (tcnt_clr)      tcnt_q <= '0;
      else if (tcnt_inc) tcnt_q <= tcnt_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_imem_line_fetch.sv
`timescale 1ns/1ps
// Bench for imem_line_fetch: directed line table, hand corner sequences and
// randomized lines checked against a transaction-level timeline model.
module tb_imem_line_fetch;
  localparam int unsigned LW  = 64;
  localparam int          TMO = 4;

  logic          clk = 1'b0;
  logic          rst, ld_line, flush;
  logic [31:0]   line_addr_i;
  logic          line_ready, line_valid, line_err_o;
  logic [LW-1:0] line_in;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0]   mem_rdata_i;

  imem_line_fetch #(.LINEWIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_line      (ld_line),
    .line_addr_i  (line_addr_i),
    .flush        (flush),
    .line_ready   (line_ready),
    .line_valid   (line_valid),
    .line_in      (line_in),
    .line_err_o   (line_err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  always #5 clk = ~clk;

  // One line transaction: memory-side plan plus expected outcome.
  // Cycle 0 is the ld_line cycle; -1 means "never".
  typedef struct {
    logic [31:0] addr;
    int          gd0, gd1;   // REQ cycles before gnt, per beat
    int          rd0, rd1;   // cycles from gnt to rvalid, per beat (>=1)
    logic [31:0] d0, d1;
    logic        e0, e1;
    int          fl;         // flush cycle
    int          exp_vc;     // expected line_valid cycle
    logic        exp_err;
    logic [63:0] exp_line;
    logic        chk_line;
    int          exp_end;    // first cycle back in idle
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_line  = '0;
  logic        last_known = 1'b1;

  int sch_rs[2], sch_re[2], sch_g[2], sch_r[2];
  int sch_nreq, sch_ngnt;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int gd0, input int gd1,
                              input int rd0, input int rd1, input logic [31:0] d0,
                              input logic [31:0] d1, input logic e0, input logic e1,
                              input int fl, input int vc, input logic err,
                              input logic [63:0] ln, input logic chk, input int en);
    vec_t v;
    v.addr = a; v.gd0 = gd0; v.gd1 = gd1; v.rd0 = rd0; v.rd1 = rd1;
    v.d0 = d0; v.d1 = d1; v.e0 = e0; v.e1 = e1; v.fl = fl;
    v.exp_vc = vc; v.exp_err = err; v.exp_line = ln; v.chk_line = chk; v.exp_end = en;
    return v;
  endfunction

  // Timeline model: walks the beats, placing req/gnt/rvalid on absolute cycles,
  // then decides the outcome from where flush or a timeout lands.
  task automatic model(input vec_t v, output vec_t m);
    int s, g, r, t, gd, rd;
    m = v;
    m.exp_vc = -1; m.exp_err = 1'b0; m.exp_line = {v.d1, v.d0};
    m.chk_line = 1'b1; m.exp_end = 0;
    sch_nreq = 0; sch_ngnt = 0;
    s = 1;
    for (int k = 0; k < 2; k++) begin
      gd = (k == 0) ? v.gd0 : v.gd1;
      rd = (k == 0) ? v.rd0 : v.rd1;
      g = s + gd;
      r = g + rd;
      t = (rd > TMO) ? g + TMO : -1;
      sch_rs[k] = s; sch_g[k] = g; sch_r[k] = r; sch_nreq = k + 1;
      if (v.fl >= s && v.fl < g) begin
        sch_re[k] = v.fl;
        m.exp_end = v.fl + 1;
        return;
      end
      sch_re[k] = g;
      sch_ngnt  = k + 1;
      if (v.fl >= g && v.fl <= r && (t < 0 || v.fl <= t)) begin
        m.exp_end = r + 1;
        return;
      end
      if (t >= 0) begin
        m.exp_vc = t; m.exp_err = 1'b1; m.chk_line = 1'b0; m.exp_end = r + 1;
        return;
      end
      if (k == 1) begin
        m.exp_vc = r; m.exp_err = v.e0 | v.e1; m.exp_end = r + 1;
        return;
      end
      s = r + 1;
    end
  endtask

  // Drives one line (schedule from the model) and checks every cycle against v.
  task automatic run_line(input string tag, input vec_t v);
    vec_t        m;
    logic [31:0] base;
    logic        exp_req;
    int          kreq;
    model(v, m);
    base = v.addr & 32'hFFFF_FFF8;
    for (int cyc = 0; cyc <= v.exp_end; cyc++) begin
      @(posedge clk); #1;
      ld_line      = (cyc == 0);
      line_addr_i  = (cyc == 0) ? v.addr : $urandom;
      flush        = (cyc == v.fl);
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      mem_err_i    = 1'($urandom_range(0, 1));
      for (int k = 0; k < sch_ngnt; k++) begin
        if (cyc == sch_g[k]) mem_gnt_i = 1'b1;
        if (cyc == sch_r[k]) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = (k == 0) ? v.d0 : v.d1;
          mem_err_i    = (k == 0) ? v.e0 : v.e1;
        end
      end
      @(negedge clk);
      exp_req = 1'b0;
      kreq    = 0;
      for (int k = 0; k < sch_nreq; k++)
        if (cyc >= sch_rs[k] && cyc <= sch_re[k]) begin
          exp_req = 1'b1;
          kreq    = k;
        end
      check({tag, ".req"}, 64'(mem_req_o), 64'(exp_req));
      if (exp_req) check({tag, ".addr"}, 64'(mem_addr_o), 64'(base + 32'(4 * kreq)));
      check({tag, ".valid"}, 64'(line_valid), 64'(cyc == v.exp_vc));
      if (cyc == v.exp_vc) begin
        check({tag, ".err"}, 64'(line_err_o), 64'(v.exp_err));
        if (v.chk_line) begin
          check({tag, ".line"}, line_in, v.exp_line);
          last_line  = v.exp_line;
          last_known = 1'b1;
        end else begin
          last_known = 1'b0;
        end
      end
      check({tag, ".ready"}, 64'(line_ready), 64'(cyc == 0 || cyc == v.exp_end));
      if (cyc == v.exp_end && last_known) check({tag, ".hold"}, line_in, last_line);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v, m;

    //            addr         gd0 gd1 rd0 rd1 d0            d1            e0 e1 fl  vc err line                    chk end
    tbl[0]  = mk(32'h0000_100C, 0, 0, 1, 1, 32'h1111_1111, 32'h2222_2222, 0, 0, -1, 4, 0, 64'h2222_2222_1111_1111, 1, 5);
    tbl[1]  = mk(32'h0000_1008, 3, 0, 1, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 0, -1, 7, 0, 64'h5A5A_5A5A_A5A5_A5A5, 1, 8);
    tbl[2]  = mk(32'h0000_100C, 0, 0, 3, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0,  2,-1, 0, 64'h0,                   0, 5);
    tbl[3]  = mk(32'h0000_2000, 0, 0, 1, 1, 32'h3333_3333, 32'h4444_4444, 0, 0, -1, 4, 0, 64'h4444_4444_3333_3333, 1, 5);
    tbl[4]  = mk(32'h0000_3004, 0, 1, 2, 1, 32'h0123_4567, 32'h89AB_CDEF, 0, 1, -1, 6, 1, 64'h89AB_CDEF_0123_4567, 1, 7);
    tbl[5]  = mk(32'h0000_3010, 0, 0, 1, 2, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 0, 0, -1, 5, 0, 64'hF0F0_F0F0_0F0F_0F0F, 1, 6);
    tbl[6]  = mk(32'h0000_4000, 0, 0, 6, 1, 32'h7777_7777, 32'h8888_8888, 0, 0, -1, 5, 1, 64'h0,                   0, 8);
    tbl[7]  = mk(32'h0000_4010, 0, 0, 4, 4, 32'h1357_9BDF, 32'h2468_ACE0, 0, 0, -1,10, 0, 64'h2468_ACE0_1357_9BDF, 1,11);
    tbl[8]  = mk(32'h0000_500C, 0, 0, 1, 5, 32'h9999_9999, 32'hAAAA_AAAA, 0, 0, -1, 7, 1, 64'h0,                   0, 9);
    tbl[9]  = mk(32'h0000_6000, 2, 0, 2, 1, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 0, 0,  3,-1, 0, 64'h0,                   0, 6);
    tbl[10] = mk(32'h0000_6008, 2, 0, 1, 1, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 0, 0,  2,-1, 0, 64'h0,                   0, 3);
    tbl[11] = mk(32'h0000_7000, 0, 0, 1, 1, 32'h1212_1212, 32'h3434_3434, 0, 0,  4,-1, 0, 64'h0,                   0, 5);
    tbl[12] = mk(32'h0000_7008, 0, 0, 6, 1, 32'h5656_5656, 32'h7878_7878, 0, 0,  6, 5, 1, 64'h0,                   0, 8);

    rst = 1'b1; ld_line = 1'b0; flush = 1'b0; line_addr_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 64'(line_ready), 64'd1);
    check("rst.valid", 64'(line_valid), 64'd0);
    check("rst.err",   64'(line_err_o), 64'd0);
    check("rst.req",   64'(mem_req_o),  64'd0);
    check("rst.addr",  64'(mem_addr_o), 64'd0);
    check("rst.line",  line_in,         64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) run_line($sformatf("tbl%0d", i), tbl[i]);

    // flush together with ld_line in idle: the request is dropped
    @(posedge clk); #1;
    ld_line = 1'b1; flush = 1'b1; line_addr_i = 32'h0000_8000;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("drop.ready", 64'(line_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ld_line = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("drop.req",   64'(mem_req_o),  64'd0);
      check("drop.ready", 64'(line_ready), 64'd1);
      check("drop.valid", 64'(line_valid), 64'd0);
    end

    // reset while requesting, then a stale rvalid that must be ignored
    @(posedge clk); #1;
    ld_line = 1'b1; line_addr_i = 32'h0000_9004;
    @(posedge clk); #1;
    ld_line = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rreq.req",  64'(mem_req_o),  64'd1);
    check("rreq.addr", 64'(mem_addr_o), 64'h9000);
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rreq.req2",  64'(mem_req_o),  64'd0);
    check("rreq.ready", 64'(line_ready), 64'd1);
    check("rreq.valid", 64'(line_valid), 64'd0);
    check("rreq.addr2", 64'(mem_addr_o), 64'd0);
    check("rreq.line",  line_in,         64'd0);
    last_line = '0; last_known = 1'b1;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    @(negedge clk);
    check("rreq.valid2", 64'(line_valid), 64'd0);
    run_line("postrst", tbl[0]);

    // randomized lines against the timeline model
    for (int n = 0; n < 150; n++) begin
      v.addr = $urandom;
      v.gd0  = int'($urandom_range(0, 2));
      v.gd1  = int'($urandom_range(0, 2));
      v.rd0  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO + 1, TMO + 2)) : int'($urandom_range(1, TMO));
      v.rd1  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO + 1, TMO + 2)) : int'($urandom_range(1, TMO));
      v.d0   = $urandom;
      v.d1   = $urandom;
      v.e0   = ($urandom_range(0, 7) == 0);
      v.e1   = ($urandom_range(0, 7) == 0);
      v.fl   = -1;
      model(v, m);
      if ($urandom_range(0, 2) == 0) begin
        v.fl = int'($urandom_range(1, m.exp_end - 1));
        model(v, m);
      end
      run_line("rnd", m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
